// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct fields and a 32-bit immediate
// into an instruction word, tagged with a running word address, through a two-stage valid/ready pipe.
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              s1_valid;
  logic [31:0]       s1_instr;
  logic              s1_err;
  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       enc_instr;
  logic              enc_err;
  logic              s2_adv;
  logic              s1_adv;
  logic              s1_move;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign s1_move  = s1_valid && s2_adv;
  assign in_ready = s1_adv;

  // Scatter the immediate per format; the range check flags values whose upper bits
  // would be lost, while the word is still packed from the truncated bits.
  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b1;
    case (fmt)
      3'd0: begin
        enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err   = 1'b0;
      end
      3'd1: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err   = (imm[31:11] != '0) && (imm[31:11] != '1);
      end
      3'd2: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err   = (imm[31:11] != '0) && (imm[31:11] != '1);
      end
      3'd3: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err   = ((imm[31:12] != '0) && (imm[31:12] != '1)) || imm[0];
      end
      3'd4: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_err   = (imm[11:0] != '0);
      end
      3'd5: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err   = ((imm[31:20] != '0) && (imm[31:20] != '1)) || imm[0];
      end
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_err   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_instr <= enc_instr;
        s1_err   <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= s1_instr;
        out_addr  <= addr_cnt;
        out_err   <= s1_err;
      end
    end
  end

  // A load wins over the +4 step; an entry moving on the same edge keeps the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (addr_load) begin
      addr_cnt <= addr_val & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    end else if (s1_move) begin
      addr_cnt <= addr_cnt + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases from the encoding rules plus
// randomized traffic scored against an arithmetic reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        addr_load;
  logic [31:0] addr_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  instr_encoder #(.ADDR_W(32), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .addr_load(addr_load), .addr_val(addr_val), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] obsInstr[$];
  logic [31:0] obsAddr[$];
  logic        obsErr[$];
  int          checkCount = 0;
  int          passCount  = 0;
  int          readyMode  = 1;
  logic [31:0] nextAddr   = '0;
  int          errModel   = 0;
  logic        heldValid  = 1'b0;
  logic [31:0] heldInstr, heldAddr;
  logic        heldErr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference encoder from the format rules using shifts/masks and signed ranges.
  function automatic logic [32:0] modelEncode(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    int          si;
    logic [31:0] regs;
    si   = $signed(im);
    regs = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    w    = 32'h13;
    e    = 1'b1;
    case (f)
      3'd0: begin
        w = (32'(f7) << 25) | (32'(s2) << 20) | regs | (32'(d) << 7);
        e = 1'b0;
      end
      3'd1: begin
        w = ((im & 32'hFFF) << 20) | regs | (32'(d) << 7);
        e = (si < -2048) || (si > 2047);
      end
      3'd2: begin
        w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | regs | ((im & 32'h1F) << 7);
        e = (si < -2048) || (si > 2047);
      end
      3'd3: begin
        w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | regs
          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7);
        e = (si < -4096) || (si > 4095) || ((im & 32'd1) != 0);
      end
      3'd4: begin
        w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
        e = (im & 32'hFFF) != 0;
      end
      3'd5: begin
        w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'd1) << 20)
          | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
        e = (si < -1048576) || (si > 1048575) || ((im & 32'd1) != 0);
      end
      default: begin
        w = 32'h13;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  always begin
    @(negedge clk);
    #2;
    case (readyMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor samples just before each rising edge; handshakes seen here complete on that edge.
  always begin
    exp_t        e;
    logic [32:0] r;
    @(negedge clk);
    #4;
    if (rst) begin
      expQ.delete();
      nextAddr  = '0;
      errModel  = 0;
      heldValid = 1'b0;
    end else begin
      if (heldValid) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_instr", out_instr, heldInstr);
        checkOutput("hold_addr", out_addr, heldAddr);
        checkOutput("hold_err", out_err, heldErr);
      end
      if (out_valid && out_ready) begin
        obsInstr.push_back(out_instr);
        obsAddr.push_back(out_addr);
        obsErr.push_back(out_err);
        if (expQ.size() == 0) begin
          checkOutput("spurious_out", out_valid, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("instr", out_instr, e.instr);
          checkOutput("addr", out_addr, e.addr);
          checkOutput("err", out_err, e.err);
          checkOutput("err_count", err_count, errModel);
          if (e.err && errModel < 255) errModel++;
        end
      end
      if (addr_load) nextAddr = addr_val & ~32'd3;
      if (in_valid && in_ready) begin
        r = modelEncode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        expQ.push_back({r[31:0], r[32], nextAddr});
        nextAddr = nextAddr + 32'd4;
      end
      heldValid = out_valid && !out_ready;
      heldInstr = out_instr;
      heldAddr  = out_addr;
      heldErr   = out_err;
    end
  end

  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im);
    logic accepted;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 200 && !accepted; i++) begin
      #3;
      accepted = in_ready;
      @(negedge clk);
      #1;
    end
    if (!accepted) checkOutput("accept_timeout", in_ready, 1);
  endtask

  task automatic waitDrain();
    in_valid = 1'b0;
    for (int i = 0; i < 500 && (expQ.size() != 0 || out_valid); i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("drain", expQ.size(), 0);
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic clearObs();
    obsInstr.delete();
    obsAddr.delete();
    obsErr.delete();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_val = '0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_instr", out_instr, 0);
    checkOutput("rst_addr", out_addr, 0);
    checkOutput("rst_err", out_err, 0);
    checkOutput("rst_errcnt", err_count, 0);
    rst = 1'b0;

    // addi x1,x0,5: held in S1 after the accept edge, visible one edge later
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b0;
    checkOutput("lat_s1", out_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("lat_s2", out_valid, 1);
    checkOutput("addi", out_instr, 32'h00500093);
    checkOutput("addi_addr", out_addr, 0);
    waitDrain();

    doReset();
    clearObs();
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    waitDrain();
    checkOutput("sw", obsInstr[0], 32'h0020A423);
    checkOutput("beq", obsInstr[1], 32'hFE000EE3);
    checkOutput("jal", obsInstr[2], 32'h001000EF);
    checkOutput("lui", obsInstr[3], 32'h123452B7);
    checkOutput("b2b_addr3", obsAddr[3], 12);

    clearObs();
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001);
    applyStimulus(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'd0);
    applyStimulus(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2047);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000);
    waitDrain();
    checkOutput("i_range", {obsErr[0], obsInstr[0]}, {1'b1, 32'h80000093});
    checkOutput("b_odd", obsErr[1], 1);
    checkOutput("u_low", obsErr[2], 1);
    checkOutput("fmt7", {obsErr[3], obsInstr[3]}, {1'b1, 32'h00000013});
    checkOutput("i_min_ok", obsErr[4], 0);
    checkOutput("err_count4", err_count, 4);

    doReset();
    clearObs();
    readyMode = 0;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    applyStimulus(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    fmt = 3'd1; rd = 5'd3; imm = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #3;
      checkOutput("bp_in_ready", in_ready, 0);
      @(negedge clk);
      #1;
    end
    readyMode = 1;
    applyStimulus(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    waitDrain();
    checkOutput("bp_order0", {obsInstr[0], obsAddr[0]}, {32'h00100093, 32'd0});
    checkOutput("bp_order1", {obsInstr[1], obsAddr[1]}, {32'h00200113, 32'd4});
    checkOutput("bp_order2", {obsInstr[2], obsAddr[2]}, {32'h00300193, 32'd8});

    clearObs();
    addr_load = 1'b1;
    addr_val  = 32'h103;
    @(negedge clk);
    #1;
    addr_load = 1'b0;
    applyStimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    applyStimulus(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
    waitDrain();
    checkOutput("load_addr0", obsAddr[0], 32'h100);
    checkOutput("load_addr1", obsAddr[1], 32'h104);
    clearObs();
    applyStimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    addr_load = 1'b1;
    addr_val  = 32'h200;
    applyStimulus(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'd0, 32'd0);
    addr_load = 1'b0;
    waitDrain();
    checkOutput("coinc_old", obsAddr[0], 32'h108);
    checkOutput("coinc_new", obsAddr[1], 32'h200);

    applyStimulus(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    waitDrain();
    readyMode = 0;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    applyStimulus(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_errcnt", err_count, 0);
    checkOutput("mid_rst_addr", out_addr, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    readyMode = 1;
    clearObs();
    applyStimulus(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    waitDrain();
    checkOutput("post_rst_addr", obsAddr[0], 0);

    readyMode = 2;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] im;
      case ($urandom_range(0, 3))
        0:       im = $urandom;
        1:       im = $urandom_range(0, 8191) - 32'd4096;
        2:       im = $urandom_range(0, 32'h3FFFFF) - 32'h200000;
        default: im = $urandom & 32'hFFFFF000;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom), 7'($urandom), im);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        #1;
      end
    end
    readyMode = 1;
    waitDrain();

    for (int n = 0; n < 300; n++)
      applyStimulus(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    waitDrain();
    checkOutput("err_sat", err_count, 255);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
